// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receive controller: synchronises rx, gates an external baud tick
// generator and delivers one byte per start bit with rcv/frame_err strobes.
//   IDLE  | waiting for a falling edge on the synchronised line
//   START | baud generator running; mid-start-bit tick confirms the start
//   DATA  | shifting in DATA_BITS data bits, LSB first
//   STOP  | sampling the stop bit; strobe rcv or frame_err
module uart_rx_ctrl #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  input  logic                 baud_tick,
  output logic                 baud_en,
  output logic [DATA_BITS-1:0] data,
  output logic                 rcv,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS) + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q;
  logic                 rx_m_q, rx_s_q, rx_d_q;
  logic [DATA_BITS-1:0] shift_q, data_q;
  logic [CW-1:0]        bitcnt_q;
  logic                 baud_en_q, rcv_q, frame_err_q;
  logic                 start_det;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
      rx_d_q <= rx_s_q;
    end
  end

  // Edge, not level: a line held low (break) must not retrigger.
  assign start_det = ~rx_s_q & rx_d_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      data_q      <= '0;
      baud_en_q   <= 1'b0;
      rcv_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rcv_q       <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_det) begin
            state_q   <= START;
            baud_en_q <= 1'b1;
          end
        end
        START: begin
          if (baud_tick) begin
            if (!rx_s_q) begin
              state_q  <= DATA;
              bitcnt_q <= '0;
            end else begin
              state_q   <= IDLE;
              baud_en_q <= 1'b0;
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            shift_q  <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            bitcnt_q <= bitcnt_q + CW'(1);
            if (bitcnt_q == CW'(DATA_BITS - 1)) state_q <= STOP;
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (rx_s_q) begin
              data_q <= shift_q;
              rcv_q  <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q   <= IDLE;
            baud_en_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          baud_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign baud_en   = baud_en_q;
  assign data      = data_q;
  assign rcv       = rcv_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table of 8N1 frames plus hand-written
// reset, glitch, break and mid-frame-reset sequences against a baud tick model.
module tb_uart_rx_ctrl;

  localparam int BIT = 104;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       baud_tick = 1'b0;
  logic       baud_en;
  logic [7:0] data;
  logic       rcv;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int n_rcv = 0;
  int n_ferr = 0;
  int busy_cycles = 0;
  int ph = BIT/2 - 1;
  logic prev_rcv = 1'b0;
  logic prev_ferr = 1'b0;

  uart_rx_ctrl #(.DATA_BITS(8)) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .baud_tick(baud_tick),
    .baud_en(baud_en), .data(data), .rcv(rcv), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Baud generator model: first tick half a bit after enable, then one per bit.
  always @(negedge clk) begin
    if (baud_en !== 1'b1) begin
      baud_tick = 1'b0;
      ph = BIT/2 - 1;
    end else if (ph == 0) begin
      baud_tick = 1'b1;
      ph = BIT - 1;
    end else begin
      baud_tick = 1'b0;
      ph--;
    end
  end

  // Strobe monitor.
  always @(negedge clk) begin
    if (rstn) begin
      if (busy === 1'b1) busy_cycles++;
      if (rcv === 1'b1) n_rcv++;
      if (frame_err === 1'b1) n_ferr++;
      if (rcv === 1'b1 || frame_err === 1'b1) begin
        check("strobe_idle", {30'd0, busy, baud_en}, 32'd0);
        check("strobe_excl", {31'd0, rcv & frame_err}, 32'd0);
        check("strobe_width", {30'd0, prev_rcv, prev_ferr}, 32'd0);
      end
    end
    prev_rcv  = rcv;
    prev_ferr = frame_err;
  end

  task automatic drive_bits(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bits(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bits(b[i], BIT);
    drive_bits(stop, BIT);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       exp_rcv;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tv[5];

  initial begin
    int r0, f0, b0;
    logic seen;

    tv[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5};
    tv[1] = '{8'h00, 1'b1, 1'b1, 8'h00};
    tv[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF};
    tv[3] = '{8'h3C, 1'b1, 1'b1, 8'h3C};
    tv[4] = '{8'h55, 1'b0, 1'b0, 8'h3C};

    // Reset with rx toggling
    repeat (3) begin
      @(negedge clk);
      rx = ~rx;
    end
    @(negedge clk);
    check("reset_outputs", {20'd0, baud_en, rcv, frame_err, busy, data}, 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_reset", {30'd0, busy, baud_en}, 32'd0);

    // Single byte, then back-to-back frames, then stop-low frame
    for (int i = 0; i < 5; i++) begin
      r0 = n_rcv;
      f0 = n_ferr;
      send_frame(tv[i].b, tv[i].stop);
      check($sformatf("vec%0d_rcv", i), n_rcv - r0, {31'd0, tv[i].exp_rcv});
      check($sformatf("vec%0d_ferr", i), n_ferr - f0, {31'd0, ~tv[i].exp_rcv});
      check($sformatf("vec%0d_data", i), {24'd0, data}, {24'd0, tv[i].exp_data});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
    end

    // Break: line stays low for 3 frames, no retrigger
    r0 = n_rcv;
    f0 = n_ferr;
    b0 = busy_cycles;
    drive_bits(1'b0, 3 * 10 * BIT);
    check("break_no_busy", busy_cycles - b0, 32'd0);
    drive_bits(1'b1, 2 * BIT);
    check("break_no_strobe", (n_rcv - r0) + (n_ferr - f0), 32'd0);
    check("break_data_kept", {24'd0, data}, 32'h3C);

    // Glitch: 20 low cycles look like a start but fail the mid-bit check
    r0 = n_rcv;
    f0 = n_ferr;
    b0 = busy_cycles;
    drive_bits(1'b0, 20);
    rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (busy_cycles != b0 && busy === 1'b0) seen = 1'b1;
    end
    check("glitch_returns_idle", {31'd0, seen}, 32'd1);
    check("glitch_busy_len", busy_cycles - b0, BIT/2);
    check("glitch_no_strobe", (n_rcv - r0) + (n_ferr - f0), 32'd0);
    drive_bits(1'b1, BIT);

    // Reset during data bit 4 of 0x81
    r0 = n_rcv;
    f0 = n_ferr;
    drive_bits(1'b0, BIT);
    drive_bits(1'b1, BIT);
    drive_bits(1'b0, BIT);
    drive_bits(1'b0, BIT);
    drive_bits(1'b0, BIT);
    drive_bits(1'b0, BIT/2);
    check("midframe_busy", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check("midframe_reset_outputs", {20'd0, baud_en, rcv, frame_err, busy, data}, 32'd0);
    drive_bits(1'b0, BIT/2 - 1);
    drive_bits(1'b0, 2 * BIT);
    drive_bits(1'b1, 2 * BIT);
    rstn = 1'b1;
    drive_bits(1'b1, BIT);
    check("midframe_no_strobe", (n_rcv - r0) + (n_ferr - f0), 32'd0);
    check("midframe_idle", {31'd0, busy}, 32'd0);

    r0 = n_rcv;
    f0 = n_ferr;
    send_frame(8'h42, 1'b1);
    check("after_reset_rcv", n_rcv - r0, 32'd1);
    check("after_reset_ferr", n_ferr - f0, 32'd0);
    check("after_reset_data", {24'd0, data}, 32'h42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller for the image-receiver path. It watches the serial line, sequences an external baud tick generator through `baud_en`, and samples one 8N1 character per start bit. It delivers the byte with a one-cycle strobe, or flags a framing error. It sits between the board RX pin and the byte consumer that fills the VGA image buffer.

## Interface
- `DATA_BITS`, 8, data bits per character; LSB first; no parity; one stop bit.
- `clk`  input  1  system clock (12 MHz on board); all logic on rising edge.
- `rstn`  input  1  reset; synchronous, active-low.
- `rx`  input  1  asynchronous serial line; idle high.
- `baud_tick`  input  1  one-cycle pulse from the baud generator. Contract: one pulse per bit period while `baud_en`=1, first pulse half a bit period after `baud_en` rises.
- `baud_en`  output  1  enable to the baud generator; high only while a character is in progress.
- `data`  output  DATA_BITS  last received character; holds until the next good character.
- `rcv`  output  1  one-cycle strobe; `data` is valid in the same cycle.
- `frame_err`  output  1  one-cycle strobe; stop bit was sampled low.
- `busy`  output  1  high whenever state is not IDLE.

## Operation
- `rx` passes through 2 flip-flops (`rx_s`), then 1 more stage (`rx_d`) for edge detection. All three reset to 1.
- Start condition: `rx_s`=0 and `rx_d`=1 (a falling edge). A constant-low line does not retrigger.
- **IDLE**: `baud_en`=0; `baud_tick` is ignored. On a start condition go to START.
- **START**: `baud_en`=1. On `baud_tick`:
  - `rx_s`=0: go to DATA, clear `bitcnt`.
  - `rx_s`=1: false start (glitch); go to IDLE with no strobe.
- **DATA**: on each `baud_tick`:
  - `shift <= {rx_s, shift[DATA_BITS-1:1]}` (LSB first).
  - `bitcnt` increments. `bitcnt` is $clog2(DATA_BITS)+1 bits wide.
  - On the tick where `bitcnt`=DATA_BITS-1, go to STOP.
- **STOP**: on `baud_tick`:
  - `rx_s`=1: `data <= shift`, `rcv` pulses.
  - `rx_s`=0: `frame_err` pulses, `data` unchanged.
  - Either way, go to IDLE.
- `baud_en` is a registered output: 1 in START, DATA and STOP; 0 otherwise.
- `rcv` and `frame_err` are registered, never high together, and each lasts exactly one cycle.
- A `baud_tick` in the same cycle as a state change is consumed only by the current state. Ticks are never queued.

## Timing
- Reset (`rstn`=0 at a rising edge) gives: state IDLE, `baud_en`=0, `data`=0, `rcv`=0, `frame_err`=0, `busy`=0, `shift`=0, `bitcnt`=0, sync regs = 1.
- Reset mid-frame aborts with no strobe. After release, a new falling edge is required to start.
- Start detection: line falls at edge E → `rx_s`=0 after edge E+2 → state START and `baud_en`=1 after edge E+3.
- Sampling: each tick is sampled in the cycle it is high. The resulting state, `shift` and output changes are visible after that edge.
- `rcv`/`frame_err` go high on the edge that consumes the stop-bit tick, and low on the next edge.
- `busy` and `baud_en` fall on that same edge. The controller can accept a new start edge on the following cycle, which allows back-to-back characters at zero idle bits.
- Per character: 10 ticks (start + 8 data + stop). Frame length ≈ 9.5 bit periods from the line fall to the strobe.

## Test plan
- **Reset**: hold `rstn`=0 for 3 cycles with `rx` toggling → all outputs 0 and `busy`=0; `baud_en` stays 0.
- **Single byte**: 12 MHz, 115200 bd generator model (104 clk/bit); send 0xA5 8N1 → exactly one `rcv` pulse, `data`=0xA5, `frame_err` never high, `baud_en` low within 1 cycle after the strobe.
- **Back-to-back**: send 0x00, 0xFF, 0x3C with no idle gap → three `rcv` pulses in order, `data`=0x00, 0xFF, 0x3C; no false starts.
- **Glitch**: drive `rx` low for 20 cycles, then high → `busy` high until the first tick, then return to IDLE; no `rcv`, no `frame_err`.
- **Framing/break**: send 0x55 with stop bit low, then hold `rx` low for 3 frames → one `frame_err` pulse, `data` keeps its previous value, no retrigger until `rx` rises and falls again.
- **Reset mid-frame**: assert `rstn` during data bit 4 of 0x81 → outputs return to reset values next edge; a following 0x42 is received correctly.
